// File: rtl/npm_pm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npm_pm_pkg: shared PCommand indices, CAL/TM state encodings, NAND    |
// | command opcodes. Revision: 1.0                                       |
// +----------------------------------------------------------------------+
package npm_pm_pkg;

  localparam int PCMD_TM  = 0;
  localparam int PCMD_CAL = 3;

  typedef enum logic [2:0] {
    CAL_IDLE    = 3'd0,
    CAL_CAPTURE = 3'd1,
    CAL_WE_LOW  = 3'd2,
    CAL_WE_HIGH = 3'd3,
    CAL_LAST    = 3'd4
  } cal_state_e;

  typedef enum logic [1:0] {
    TM_IDLE  = 2'd0,
    TM_COUNT = 2'd1,
    TM_LAST  = 2'd2
  } tm_state_e;

  localparam logic [7:0] NAND_CMD_ERASE_SETUP   = 8'h60;
  localparam logic [7:0] NAND_CMD_ERASE_CONFIRM = 8'hD0;
  localparam logic [7:0] NAND_CMD_SLC_MODE      = 8'hA2;
  localparam logic [7:0] NAND_CMD_RESET_LUN     = 8'hFA;
  localparam logic [7:0] NAND_CMD_OP_27         = 8'h27;

endpackage
`default_nettype wire

// File: rtl/npm_cal_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npm_cal_buffer: Depth x 9-bit CAL byte capture buffer with sticky    |
// | overflow flag. Revision: 1.0                                         |
// +----------------------------------------------------------------------+
module npm_cal_buffer #(
  parameter int Depth = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_clr,
  input  logic       wr_en,
  input  logic [8:0] wr_data,
  input  logic       rd_clr,
  input  logic       rd_inc,
  output logic [8:0] rd_data,
  output logic       overflow
);

  localparam int AW = $clog2(Depth);
  localparam logic [16:0] DEPTH17 = 17'(Depth);

  logic [8:0]    mem_q [Depth];
  logic [16:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          mem_we;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (wr_clr) begin
      wr_cnt_d = '0;
    end else if (wr_en) begin
      // Bytes past the buffer depth are dropped but still counted.
      if (wr_cnt_q < DEPTH17) mem_we = 1'b1;
      else                    ovf_d  = 1'b1;
      wr_cnt_d = wr_cnt_q + 17'd1;
    end
    if (rd_clr)      rd_ptr_d = '0;
    else if (rd_inc) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_cnt_q[AW-1:0]] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: rtl/npm_toggle_cal_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npm_toggle_cal_timer: PM-side CAL (command/address latch) and TM     |
// | (timer) primitive responder driving NAND CE_n/CLE/ALE/WE_n/DQ.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module npm_toggle_cal_timer
  import npm_pm_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int CALDepth     = 8,
  parameter int WELowCycles  = 2,
  parameter int WEHighCycles = 2
) (
  input  logic                    iSystemClock,
  input  logic                    iReset_n,
  input  logic [7:0]              iPM_PCommand,
  input  logic [2:0]              iPM_PCommandOption,
  input  logic [NumberOfWays-1:0] iPM_TargetWay,
  input  logic [15:0]             iPM_NumOfData,
  input  logic                    iPM_CASelect,
  input  logic [7:0]              iPM_CAData,
  output logic [7:0]              oPM_Ready,
  output logic [7:0]              oPM_LastStep,
  output logic [NumberOfWays-1:0] oNAND_CE_n,
  output logic                    oNAND_CLE,
  output logic                    oNAND_ALE,
  output logic                    oNAND_WE_n,
  output logic [7:0]              oNAND_DQ,
  output logic                    oNAND_DQOE,
  output logic                    oCALOverflow
);

  localparam logic [16:0] DEPTH17 = 17'(CALDepth);
  localparam logic [7:0]  WEL_END = 8'(WELowCycles - 1);
  localparam logic [7:0]  WEH_END = 8'(WEHighCycles - 1);

  cal_state_e cal_state_q, cal_state_d;
  tm_state_e  tm_state_q, tm_state_d;

  logic [NumberOfWays-1:0] cal_way_q, cal_way_d, tm_way_q, tm_way_d;
  logic [16:0] cal_n_q, cal_n_d, byte_cnt_q, byte_cnt_d, drive_total;
  logic [7:0]  phase_q, phase_d;
  logic [2:0]  tm_opt_q, tm_opt_d;
  logic [15:0] tm_cnt_q, tm_cnt_d;

  logic [NumberOfWays-1:0] ce_n_q, ce_n_d;
  logic       cle_q, cle_d, ale_q, ale_d, we_n_q, we_n_d, dqoe_q, dqoe_d;
  logic [7:0] dq_q, dq_d;

  logic       buf_wr_clr, buf_wr_en, buf_rd_clr, buf_rd_inc;
  logic [8:0] buf_rd_data;

  logic cal_idle, cal_last, cal_accept, cal_drive, tm_idle, tm_last, tm_ready, tm_accept;
  logic unused_ok;

  assign cal_idle    = (cal_state_q == CAL_IDLE);
  assign cal_last    = (cal_state_q == CAL_LAST);
  assign cal_drive   = (cal_state_q == CAL_WE_LOW) || (cal_state_q == CAL_WE_HIGH);
  assign tm_idle     = (tm_state_q == TM_IDLE);
  assign tm_last     = (tm_state_q == TM_LAST);
  assign cal_accept  = cal_idle & iPM_PCommand[PCMD_CAL];
  assign tm_ready    = tm_idle & (cal_idle | cal_last);
  // A CAL trigger wins a simultaneous start; the TM waits for CAL_LAST.
  assign tm_accept   = iPM_PCommand[PCMD_TM] & tm_ready & ~cal_accept;
  assign drive_total = (cal_n_q > DEPTH17) ? DEPTH17 : cal_n_q;

  npm_cal_buffer #(.Depth(CALDepth)) u_cal_buffer (
    .clk      (iSystemClock),
    .rst_n    (iReset_n),
    .wr_clr   (buf_wr_clr),
    .wr_en    (buf_wr_en),
    .wr_data  ({iPM_CASelect, iPM_CAData}),
    .rd_clr   (buf_rd_clr),
    .rd_inc   (buf_rd_inc),
    .rd_data  (buf_rd_data),
    .overflow (oCALOverflow)
  );

  always_comb begin
    cal_state_d = cal_state_q;
    cal_way_d   = cal_way_q;
    cal_n_d     = cal_n_q;
    byte_cnt_d  = byte_cnt_q;
    phase_d     = phase_q;
    buf_wr_clr  = 1'b0;
    buf_wr_en   = 1'b0;
    buf_rd_clr  = 1'b0;
    buf_rd_inc  = 1'b0;
    case (cal_state_q)
      CAL_IDLE: begin
        if (cal_accept) begin
          cal_way_d   = iPM_TargetWay;
          cal_n_d     = {1'b0, iPM_NumOfData} + 17'd1;
          byte_cnt_d  = '0;
          buf_wr_clr  = 1'b1;
          cal_state_d = CAL_CAPTURE;
        end
      end
      CAL_CAPTURE: begin
        buf_wr_en  = 1'b1;
        byte_cnt_d = byte_cnt_q + 17'd1;
        if (byte_cnt_q == cal_n_q - 17'd1) begin
          byte_cnt_d  = '0;
          buf_rd_clr  = 1'b1;
          phase_d     = '0;
          cal_state_d = CAL_WE_LOW;
        end
      end
      CAL_WE_LOW: begin
        phase_d = phase_q + 8'd1;
        if (phase_q == WEL_END) begin
          phase_d     = '0;
          cal_state_d = CAL_WE_HIGH;
        end
      end
      CAL_WE_HIGH: begin
        phase_d = phase_q + 8'd1;
        if (phase_q == WEH_END) begin
          phase_d = '0;
          if (byte_cnt_q == drive_total - 17'd1) begin
            cal_state_d = CAL_LAST;
          end else begin
            byte_cnt_d  = byte_cnt_q + 17'd1;
            buf_rd_inc  = 1'b1;
            cal_state_d = CAL_WE_LOW;
          end
        end
      end
      CAL_LAST: cal_state_d = CAL_IDLE;
      default:  cal_state_d = CAL_IDLE;
    endcase
  end

  always_comb begin
    tm_state_d = tm_state_q;
    tm_opt_d   = tm_opt_q;
    tm_way_d   = tm_way_q;
    tm_cnt_d   = tm_cnt_q;
    case (tm_state_q)
      TM_IDLE: begin
        if (tm_accept) begin
          tm_opt_d   = iPM_PCommandOption;
          tm_way_d   = iPM_TargetWay;
          tm_cnt_d   = (iPM_NumOfData == 16'd0) ? 16'd1 : iPM_NumOfData;
          tm_state_d = TM_COUNT;
        end
      end
      TM_COUNT: begin
        if (tm_cnt_q == 16'd1) tm_state_d = TM_LAST;
        else                   tm_cnt_d   = tm_cnt_q - 16'd1;
      end
      TM_LAST: tm_state_d = TM_IDLE;
      default: tm_state_d = TM_IDLE;
    endcase
  end

  always_comb begin
    ce_n_d = ~(((cal_idle || cal_state_q == CAL_CAPTURE) ? '0 : cal_way_q) |
               ((!tm_idle && tm_opt_q[2]) ? tm_way_q : '0));
    cle_d  = cal_drive & ~buf_rd_data[8];
    ale_d  = cal_drive &  buf_rd_data[8];
    dqoe_d = cal_drive;
    dq_d   = cal_drive ? buf_rd_data[7:0] : 8'h00;
    we_n_d = (cal_state_q != CAL_WE_LOW);
  end

  always_ff @(posedge iSystemClock or negedge iReset_n) begin
    if (!iReset_n) begin
      cal_state_q <= CAL_IDLE;
      cal_way_q   <= '0;
      cal_n_q     <= '0;
      byte_cnt_q  <= '0;
      phase_q     <= '0;
      tm_state_q  <= TM_IDLE;
      tm_opt_q    <= '0;
      tm_way_q    <= '0;
      tm_cnt_q    <= '0;
      ce_n_q      <= '1;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      we_n_q      <= 1'b1;
      dq_q        <= 8'h00;
      dqoe_q      <= 1'b0;
    end else begin
      cal_state_q <= cal_state_d;
      cal_way_q   <= cal_way_d;
      cal_n_q     <= cal_n_d;
      byte_cnt_q  <= byte_cnt_d;
      phase_q     <= phase_d;
      tm_state_q  <= tm_state_d;
      tm_opt_q    <= tm_opt_d;
      tm_way_q    <= tm_way_d;
      tm_cnt_q    <= tm_cnt_d;
      ce_n_q      <= ce_n_d;
      cle_q       <= cle_d;
      ale_q       <= ale_d;
      we_n_q      <= we_n_d;
      dq_q        <= dq_d;
      dqoe_q      <= dqoe_d;
    end
  end

  assign oPM_Ready    = {4'hF, cal_idle, 2'b11, tm_ready};
  assign oPM_LastStep = {4'h0, cal_last, 2'b00, tm_last};
  assign oNAND_CE_n   = ce_n_q;
  assign oNAND_CLE    = cle_q;
  assign oNAND_ALE    = ale_q;
  assign oNAND_WE_n   = we_n_q;
  assign oNAND_DQ     = dq_q;
  assign oNAND_DQOE   = dqoe_q;

  // Option[1:0] is latched for the issuers' benefit but has no pin effect.
  assign unused_ok = ^{iPM_PCommand[7:4], iPM_PCommand[2:1], tm_opt_q[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_npm_toggle_cal_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_npm_toggle_cal_timer: directed self-checking bench for the CAL/TM |
// | responder. Revision: 1.0                                             |
// +----------------------------------------------------------------------+
module tb_npm_toggle_cal_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd;
  logic [2:0]  opt;
  logic [3:0]  way;
  logic [15:0] nod;
  logic        sel;
  logic [7:0]  data;
  logic [7:0]  ready, ls;
  logic [3:0]  ce_n;
  logic        cle, ale, we_n, dqoe, ovf;
  logic [7:0]  dq;

  always #5 clk = ~clk;

  npm_toggle_cal_timer #(
    .NumberOfWays(4), .CALDepth(8), .WELowCycles(2), .WEHighCycles(2)
  ) dut (
    .iSystemClock       (clk),
    .iReset_n           (rst_n),
    .iPM_PCommand       (cmd),
    .iPM_PCommandOption (opt),
    .iPM_TargetWay      (way),
    .iPM_NumOfData      (nod),
    .iPM_CASelect       (sel),
    .iPM_CAData         (data),
    .oPM_Ready          (ready),
    .oPM_LastStep       (ls),
    .oNAND_CE_n         (ce_n),
    .oNAND_CLE          (cle),
    .oNAND_ALE          (ale),
    .oNAND_WE_n         (we_n),
    .oNAND_DQ           (dq),
    .oNAND_DQOE         (dqoe),
    .oCALOverflow       (ovf)
  );

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [8:0] stim_b [16];

  // Per-run observations, gathered at the falling edge of each cycle.
  int         pulses, we_low, ls3_cyc, ls3_cnt, ls0_cyc, ls0_cnt, ce_bad;
  int         ce_lo, ce_hi, rdy_cyc;
  logic [7:0] rdy_exp;
  logic       prev_we;
  logic [7:0] p_dq  [16];
  logic       p_cle [16];
  logic       p_ale [16];
  logic       p_oe  [16];
  logic [3:0] p_ce  [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    pulses = 0; we_low = 0; ls3_cyc = -1; ls3_cnt = 0; ls0_cyc = -1; ls0_cnt = 0;
    ce_bad = 0; prev_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      p_dq[i] = 8'hxx; p_cle[i] = 1'bx; p_ale[i] = 1'bx; p_oe[i] = 1'bx; p_ce[i] = 4'hx;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!we_n && prev_we && pulses < 16) begin
      p_dq[pulses] = dq; p_cle[pulses] = cle; p_ale[pulses] = ale;
      p_oe[pulses] = dqoe; p_ce[pulses] = ce_n;
      pulses++;
    end
    if (!we_n) we_low++;
    prev_we = we_n;
    if (ls[3]) begin if (ls3_cnt == 0) ls3_cyc = cyc; ls3_cnt++; end
    if (ls[0]) begin if (ls0_cnt == 0) ls0_cyc = cyc; ls0_cnt++; end
    if (cyc >= ce_lo && cyc <= ce_hi && ce_n[0]) ce_bad++;
    if (cyc == rdy_cyc) chk("ready_mid_run", {24'h0, ready}, {24'h0, rdy_exp});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle 0 is the CAL accept cycle; bytes follow in cycles 1..n+1.
  task automatic run_cal(input int n, input logic [3:0] w, input int last_cyc,
                         input int busy_cyc, input int tm_from, input int tm_to,
                         input logic [2:0] tm_opt, input logic [15:0] tm_nod);
    clear_mon();
    cyc = 0;
    while (cyc <= last_cyc) begin
      cmd = 8'h00; nod = 16'(n); way = w; opt = tm_opt; sel = 1'b0; data = 8'h00;
      if (cyc == 0) cmd[3] = 1'b1;
      if (cyc >= 1 && cyc <= n + 1) {sel, data} = stim_b[cyc - 1];
      if (cyc == busy_cyc) cmd[3] = 1'b1;
      if (cyc >= tm_from && cyc <= tm_to) begin cmd[0] = 1'b1; nod = tm_nod; end
      if (cyc == 1) chk("capture_ready", {24'h0, ready}, 32'h0000_00F6);
      step();
    end
    cmd = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; cmd = 8'h00; opt = 3'b000; way = 4'b0000; nod = 16'h0;
    sel = 1'b0; data = 8'h00;
    ce_lo = -1; ce_hi = -2; rdy_cyc = -1; rdy_exp = 8'h00;
    #12;
    chk("rst_ce_n",  {28'h0, ce_n}, 32'hF);
    chk("rst_cle",   {31'h0, cle},  32'h0);
    chk("rst_ale",   {31'h0, ale},  32'h0);
    chk("rst_we_n",  {31'h0, we_n}, 32'h1);
    chk("rst_dq",    {24'h0, dq},   32'h0);
    chk("rst_dqoe",  {31'h0, dqoe}, 32'h0);
    chk("rst_ready", {24'h0, ready}, 32'hFF);
    chk("rst_ls",    {24'h0, ls},   32'h0);
    chk("rst_ovf",   {31'h0, ovf},  32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Erase: A2 60 11 22 33 D0, busy retrigger at cycle 3, TM chained from cycle 7.
    stim_b[0] = 9'h0A2; stim_b[1] = 9'h060; stim_b[2] = 9'h111;
    stim_b[3] = 9'h122; stim_b[4] = 9'h133; stim_b[5] = 9'h0D0;
    ce_lo = 8; ce_hi = 43; rdy_cyc = 35; rdy_exp = 8'hFE;
    run_cal(5, 4'b0001, 50, 3, 7, 31, 3'b110, 16'd10);
    ce_lo = -1; ce_hi = -2; rdy_cyc = -1;
    chk("erase_pulses",  pulses, 6);
    chk("erase_we_low",  we_low, 12);
    chk("erase_ls3_cyc", ls3_cyc, 31);
    chk("erase_ls3_cnt", ls3_cnt, 1);
    chk("tm_ls0_cyc",    ls0_cyc, 42);
    chk("tm_ls0_cnt",    ls0_cnt, 1);
    chk("tm_ce_hold",    ce_bad, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("erase_dq%0d", i),  {24'h0, p_dq[i]},  {24'h0, stim_b[i][7:0]});
      chk($sformatf("erase_cle%0d", i), {31'h0, p_cle[i]}, {31'h0, ~stim_b[i][8]});
      chk($sformatf("erase_ale%0d", i), {31'h0, p_ale[i]}, {31'h0, stim_b[i][8]});
      chk($sformatf("erase_ce%0d", i),  {28'h0, p_ce[i]},  32'hE);
      chk($sformatf("erase_oe%0d", i),  {31'h0, p_oe[i]},  32'h1);
    end
    chk("erase_ovf",      {31'h0, ovf},  32'h0);
    chk("erase_end_ce",   {28'h0, ce_n}, 32'hF);
    chk("erase_end_rdy",  {24'h0, ready}, 32'hFF);

    // Overflow: 10 bytes into an 8-deep buffer.
    for (int i = 0; i < 10; i++) stim_b[i] = {i[0], 8'h80 + 8'(i)};
    run_cal(9, 4'b0010, 50, -1, -1, -1, 3'b000, 16'd0);
    chk("ovf_pulses",  pulses, 8);
    chk("ovf_ls3_cyc", ls3_cyc, 43);
    chk("ovf_flag",    {31'h0, ovf}, 32'h1);
    chk("ovf_dq7",     {24'h0, p_dq[7]}, 32'h87);
    chk("ovf_ale7",    {31'h0, p_ale[7]}, 32'h1);
    chk("ovf_ce0",     {28'h0, p_ce[0]}, 32'hD);

    // Single byte 70 (command).
    stim_b[0] = 9'h070;
    run_cal(0, 4'b0001, 12, -1, -1, -1, 3'b000, 16'd0);
    chk("one_ls3_cyc", ls3_cyc, 6);
    chk("one_ls3_cnt", ls3_cnt, 1);
    chk("one_pulses",  pulses, 1);
    chk("one_we_low",  we_low, 2);
    chk("one_dq",      {24'h0, p_dq[0]}, 32'h70);
    chk("one_cle",     {31'h0, p_cle[0]}, 32'h1);
    chk("one_ale",     {31'h0, p_ale[0]}, 32'h0);
    chk("one_ls0_cnt", ls0_cnt, 0);
    chk("ovf_sticky",  {31'h0, ovf}, 32'h1);

    // Async reset while WE_n is low on an address byte to way 2.
    stim_b[0] = 9'h155;
    run_cal(0, 4'b0100, 3, -1, -1, -1, 3'b000, 16'd0);
    chk("pre_rst_we_n", {31'h0, we_n}, 32'h0);
    chk("pre_rst_ce_n", {28'h0, ce_n}, 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we_n",  {31'h0, we_n}, 32'h1);
    chk("arst_ce_n",  {28'h0, ce_n}, 32'hF);
    chk("arst_ls",    {24'h0, ls},   32'h0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    cyc = 0;
    while (cyc < 10) step();
    chk("post_rst_ready",  {24'h0, ready}, 32'hFF);
    chk("post_rst_ls3",    ls3_cnt, 0);
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_ovf",    {31'h0, ovf}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
